// File: rtl/dcache_sram_nway_if.sv
// dcache_sram_nway_if
//   Bus between the cache controller / line buffer and the N-way cache storage.
//   Carries the lookup/access port and the flush port.
//   Access port : addr_i, tag_i, data_i, enable_i, write_i   (controller -> array)
//                 tag_o, data_o, hit_o, way_o                (array -> controller)
//   Flush port  : flush_i, flush_ready_i                     (controller -> array)
//                 flush_valid_o, flush_idx_o, flush_tag_o,
//                 flush_data_o, busy_o, flush_done_o         (array -> controller)
//   Flush handshake: a line is transferred on a posedge where flush_valid_o and
//   flush_ready_i are both 1. While flush_valid_o=1 and flush_ready_i=0 the
//   presented idx/tag/data hold unchanged; flush_valid_o never drops before
//   the transfer. flush_ready_i may be high while flush_valid_o is low.
interface dcache_sram_nway_if #(
    parameter int SETS   = 16,
    parameter int WAYS   = 4,
    parameter int TAG_W  = 23,
    parameter int LINE_W = 256
);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);

    logic [IDX_W-1:0]  addr_i;
    logic [TAG_W+1:0]  tag_i;
    logic [LINE_W-1:0] data_i;
    logic              enable_i;
    logic              write_i;
    logic [TAG_W+1:0]  tag_o;
    logic [LINE_W-1:0] data_o;
    logic              hit_o;
    logic [WAY_W-1:0]  way_o;

    logic              flush_i;
    logic              flush_valid_o;
    logic              flush_ready_i;
    logic [IDX_W-1:0]  flush_idx_o;
    logic [TAG_W+1:0]  flush_tag_o;
    logic [LINE_W-1:0] flush_data_o;
    logic              busy_o;
    logic              flush_done_o;

    modport master (
        output addr_i, tag_i, data_i, enable_i, write_i, flush_i, flush_ready_i,
        input  tag_o, data_o, hit_o, way_o, flush_valid_o, flush_idx_o,
               flush_tag_o, flush_data_o, busy_o, flush_done_o
    );

    modport slave (
        input  addr_i, tag_i, data_i, enable_i, write_i, flush_i, flush_ready_i,
        output tag_o, data_o, hit_o, way_o, flush_valid_o, flush_idx_o,
               flush_tag_o, flush_data_o, busy_o, flush_done_o
    );
endinterface

// File: rtl/dcache_sram_nway.sv
// dcache_sram_nway
//   N-way set-associative data-cache storage with true-LRU replacement and a
//   sequential flush engine that hands out dirty lines one at a time.
//   Ports:
//     clk_i       clock, all state changes on posedge
//     rst_i       synchronous reset, active-low
//     bus         dcache_sram_nway_if.slave (access port + flush port)
//     dbg_state_o current flush FSM state (IDLE/SCAN/EMIT/DONE)
//   Tag entry layout is {valid, dirty, tag}. Ages per set are a permutation of
//   0..WAYS-1 with 0 = MRU and WAYS-1 = LRU.
module dcache_sram_nway #(
    parameter int SETS   = 16,
    parameter int WAYS   = 4,
    parameter int TAG_W  = 23,
    parameter int LINE_W = 256
) (
    input  logic               clk_i,
    input  logic               rst_i,
    dcache_sram_nway_if.slave  bus,
    output logic [1:0]         dbg_state_o
);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);
    localparam int PTR_W = IDX_W + WAY_W;
    localparam logic [WAY_W-1:0] AGE_LRU = WAY_W'(WAYS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    logic [TAG_W+1:0]  tag_q  [SETS][WAYS];
    logic [LINE_W-1:0] data_q [SETS][WAYS];
    logic [WAY_W-1:0]  age_q  [SETS][WAYS];

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;       // {set, way}, way in the low bits
    logic              clr_dirty;

    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic              inv_found;
    logic [WAY_W-1:0]  inv_way;
    logic [WAY_W-1:0]  lru_way;
    logic [WAY_W-1:0]  sel_way;
    logic              idle;
    logic              do_write;
    logic              do_touch;
    logic [IDX_W-1:0]  ptr_set;
    logic [WAY_W-1:0]  ptr_way;

    assign ptr_set = ptr_q[PTR_W-1:WAY_W];
    assign ptr_way = ptr_q[WAY_W-1:0];

    // Lookup. Loops run from the top way down so the lowest matching /
    // lowest invalid way is the one left standing.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (tag_q[bus.addr_i][w][TAG_W+1] &&
                (tag_q[bus.addr_i][w][TAG_W-1:0] == bus.tag_i[TAG_W-1:0])) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!tag_q[bus.addr_i][w][TAG_W+1]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
            if (age_q[bus.addr_i][w] == AGE_LRU) begin
                lru_way = WAY_W'(w);
            end
        end
        if (hit) begin
            sel_way = hit_way;
        end else if (inv_found) begin
            sel_way = inv_way;
        end else begin
            sel_way = lru_way;
        end
    end

    assign bus.hit_o  = hit;
    assign bus.way_o  = sel_way;
    assign bus.tag_o  = tag_q[bus.addr_i][sel_way];
    assign bus.data_o = data_q[bus.addr_i][sel_way];

    assign idle     = (state_q == ST_IDLE);
    assign do_write = bus.enable_i && idle && bus.write_i;
    // A read miss leaves ages alone; only writes and read hits count as use.
    assign do_touch = bus.enable_i && idle && (bus.write_i || hit);

    // Flush FSM next state
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        clr_dirty = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.flush_i) begin
                    state_d = ST_SCAN;
                    ptr_d   = '0;
                end
            end
            ST_SCAN: begin
                if (tag_q[ptr_set][ptr_way][TAG_W+1] && tag_q[ptr_set][ptr_way][TAG_W]) begin
                    state_d = ST_EMIT;
                end else if (ptr_q == '1) begin
                    state_d = ST_DONE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_EMIT: begin
                if (bus.flush_ready_i) begin
                    clr_dirty = 1'b1;
                    if (ptr_q == '1) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SCAN;
                        ptr_d   = ptr_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Storage. Accesses only happen in IDLE and dirty clears only in EMIT,
    // so the two write paths never collide.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s][w]  <= '0;
                    data_q[s][w] <= '0;
                    age_q[s][w]  <= WAY_W'(WAYS - 1 - w);
                end
            end
        end else begin
            if (do_write) begin
                tag_q[bus.addr_i][sel_way]  <= bus.tag_i;
                data_q[bus.addr_i][sel_way] <= bus.data_i;
            end
            if (do_touch) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == sel_way) begin
                        age_q[bus.addr_i][w] <= '0;
                    end else if (age_q[bus.addr_i][w] < age_q[bus.addr_i][sel_way]) begin
                        age_q[bus.addr_i][w] <= age_q[bus.addr_i][w] + 1'b1;
                    end
                end
            end
            if (clr_dirty) begin
                tag_q[ptr_set][ptr_way][TAG_W] <= 1'b0;
            end
        end
    end

    assign bus.busy_o        = !idle;
    assign bus.flush_valid_o = (state_q == ST_EMIT);
    assign bus.flush_done_o  = (state_q == ST_DONE);
    assign bus.flush_idx_o   = ptr_set;
    assign bus.flush_tag_o   = tag_q[ptr_set][ptr_way];
    assign bus.flush_data_o  = data_q[ptr_set][ptr_way];
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Self-checking bench for dcache_sram_nway: directed scenarios followed by
// randomized accesses, compared against a set/way/recency-list model.
module tb_dcache_sram_nway;
    localparam int SETS   = 16;
    localparam int WAYS   = 4;
    localparam int TAG_W  = 23;
    localparam int LINE_W = 256;
    localparam int IDX_W  = $clog2(SETS);
    localparam int WAY_W  = $clog2(WAYS);

    logic clk;
    logic rst;
    logic [1:0] dbg_state;

    dcache_sram_nway_if #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .LINE_W(LINE_W)) bus ();

    dcache_sram_nway #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [TAG_W+1:0]  m_tag  [SETS][WAYS];
    logic [LINE_W-1:0] m_data [SETS][WAYS];
    int                m_lru  [SETS][WAYS];   // ways ordered most- to least-recently used

    logic [IDX_W-1:0]  exp_idx_q  [$];
    logic [WAY_W-1:0]  exp_way_q  [$];
    logic [TAG_W+1:0]  exp_tag_q  [$];
    logic [LINE_W-1:0] exp_data_q [$];

    task automatic m_reset();
        for (int s = 0; s < SETS; s++)
            for (int p = 0; p < WAYS; p++) begin
                m_tag[s][p]  = '0;
                m_data[s][p] = '0;
                m_lru[s][p]  = WAYS - 1 - p;   // way 0 starts as least recent
            end
    endtask

    function automatic int m_hit_way(input int s, input logic [TAG_W-1:0] t);
        for (int w = 0; w < WAYS; w++)
            if (m_tag[s][w][TAG_W+1] && m_tag[s][w][TAG_W-1:0] == t) return w;
        return -1;
    endfunction

    function automatic int m_victim(input int s);
        for (int w = 0; w < WAYS; w++)
            if (!m_tag[s][w][TAG_W+1]) return w;
        return m_lru[s][WAYS-1];
    endfunction

    task automatic m_touch(input int s, input int w);
        int p;
        p = 0;
        for (int i = 0; i < WAYS; i++) if (m_lru[s][i] == w) p = i;
        for (int i = p; i > 0; i--) m_lru[s][i] = m_lru[s][i-1];
        m_lru[s][0] = w;
    endtask

    function automatic logic [LINE_W-1:0] rnd_line();
        logic [LINE_W-1:0] r;
        for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    // One access cycle: drive at negedge, check lookup, then let the edge act.
    task automatic access(input int s, input logic [TAG_W-1:0] t, input bit v, input bit d,
                          input logic [LINE_W-1:0] dat, input bit en, input bit wr);
        int hw, ew;
        @(negedge clk);
        bus.addr_i   = IDX_W'(s);
        bus.tag_i    = {v, d, t};
        bus.data_i   = dat;
        bus.enable_i = en;
        bus.write_i  = wr;
        #1;
        hw = m_hit_way(s, t);
        ew = (hw >= 0) ? hw : m_victim(s);
        check("hit_o",  bus.hit_o, (hw >= 0));
        check("way_o",  bus.way_o, ew);
        check("tag_o",  bus.tag_o, m_tag[s][ew]);
        check("data_o", bus.data_o, m_data[s][ew]);
        @(posedge clk);
        if (en) begin
            if (wr) begin
                m_tag[s][ew]  = {v, d, t};
                m_data[s][ew] = dat;
                m_touch(s, ew);
            end else if (hw >= 0) begin
                m_touch(s, hw);
            end
        end
        #1;
        bus.enable_i = 1'b0;
    endtask

    task automatic run_flush(input int hold_first, input bit rand_ready, input int exp_len);
        int k, done_k, hold;
        bit done_seen, first, rdy;
        exp_idx_q.delete(); exp_way_q.delete(); exp_tag_q.delete(); exp_data_q.delete();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                if (m_tag[s][w][TAG_W+1] && m_tag[s][w][TAG_W]) begin
                    exp_idx_q.push_back(IDX_W'(s));
                    exp_way_q.push_back(WAY_W'(w));
                    exp_tag_q.push_back(m_tag[s][w]);
                    exp_data_q.push_back(m_data[s][w]);
                end
        @(negedge clk);
        bus.flush_i  = 1'b1;
        bus.enable_i = 1'b0;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        // Accesses offered while busy must be ignored.
        bus.enable_i = 1'b1;
        bus.write_i  = 1'b1;
        bus.addr_i   = IDX_W'(5);
        bus.tag_i    = {2'b11, TAG_W'(23'h1ffff)};
        bus.data_i   = rnd_line();
        k = 0; done_k = -1; done_seen = 0; first = 1; hold = hold_first;
        while (k < 2000 && !done_seen) begin
            @(negedge clk);
            check("busy_during_flush", bus.busy_o, 1'b1);
            rdy = 1'($urandom_range(0, 1));
            if (bus.flush_valid_o) begin
                if (exp_idx_q.size() == 0) begin
                    check("flush_extra_line", 1'b1, 1'b0);
                end else begin
                    check("flush_idx",  bus.flush_idx_o,  exp_idx_q[0]);
                    check("flush_tag",  bus.flush_tag_o,  exp_tag_q[0]);
                    check("flush_data", bus.flush_data_o, exp_data_q[0]);
                    if (first && hold > 0) begin
                        rdy = 1'b0;
                        hold--;
                    end else if (!rand_ready) begin
                        rdy = 1'b1;
                    end
                    if (rdy) begin
                        first = 0;
                        m_tag[exp_idx_q[0]][exp_way_q[0]][TAG_W] = 1'b0;
                        void'(exp_idx_q.pop_front()); void'(exp_way_q.pop_front());
                        void'(exp_tag_q.pop_front()); void'(exp_data_q.pop_front());
                    end
                end
            end
            bus.flush_ready_i = rdy;
            if (bus.flush_done_o) begin
                done_seen    = 1;
                done_k       = k;
                bus.enable_i = 1'b0;
            end else begin
                k++;
            end
        end
        check("flush_done_seen", done_seen, 1'b1);
        if (exp_len >= 0) check("flush_length", done_k, exp_len);
        check("flush_lines_left", exp_idx_q.size(), 0);
        @(negedge clk);
        bus.flush_ready_i = 1'b0;
        bus.enable_i      = 1'b0;
        check("done_one_cycle", bus.flush_done_o, 1'b0);
        check("busy_after_flush", bus.busy_o, 1'b0);
        check("valid_after_flush", bus.flush_valid_o, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int k;
        bit seen;
        logic [LINE_W-1:0] pat;
        rst = 1'b0;
        bus.addr_i = '0; bus.tag_i = '0; bus.data_i = '0;
        bus.enable_i = 1'b0; bus.write_i = 1'b0;
        bus.flush_i = 1'b0; bus.flush_ready_i = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_busy",  bus.busy_o, 1'b0);
        check("rst_valid", bus.flush_valid_o, 1'b0);
        check("rst_done",  bus.flush_done_o, 1'b0);

        // Read miss in an empty set: way 0, zero entry, ages untouched.
        access(3, 23'h12, 1, 0, '0, 1, 0);

        // Fill set 5 with four clean tags, then read each back.
        access(5, 23'hA, 1, 0, rnd_line(), 1, 1);
        access(5, 23'hB, 1, 0, rnd_line(), 1, 1);
        access(5, 23'hC, 1, 0, rnd_line(), 1, 1);
        access(5, 23'hD, 1, 0, rnd_line(), 1, 1);
        access(5, 23'hD, 1, 0, '0, 1, 0);
        access(5, 23'hC, 1, 0, '0, 1, 0);
        access(5, 23'hB, 1, 0, '0, 1, 0);
        access(5, 23'hA, 1, 0, '0, 1, 0);

        // Fresh recency state for the replacement scenario.
        m_reset();
        rst = 1'b0; @(posedge clk); #1 rst = 1'b1;
        access(5, 23'hA, 1, 0, rnd_line(), 1, 1);
        access(5, 23'hB, 1, 0, rnd_line(), 1, 1);
        access(5, 23'hC, 1, 0, rnd_line(), 1, 1);
        access(5, 23'hD, 1, 0, rnd_line(), 1, 1);
        access(5, 23'hA, 1, 0, '0, 1, 0);
        // Victim for 0xE must be way 1 holding 0xB.
        @(negedge clk);
        bus.addr_i = IDX_W'(5); bus.tag_i = {2'b10, TAG_W'(23'hE)};
        #1;
        check("plan_victim_way", bus.way_o, 1);
        check("plan_victim_tag", bus.tag_o, {2'b10, TAG_W'(23'hB)});
        access(5, 23'hE, 1, 0, rnd_line(), 1, 1);
        access(5, 23'hB, 1, 0, '0, 1, 0);
        access(5, 23'hA, 1, 0, '0, 1, 0);
        access(5, 23'hC, 1, 0, '0, 1, 0);
        access(5, 23'hD, 1, 0, '0, 1, 0);
        access(5, 23'hE, 1, 0, '0, 1, 0);

        // Dirty write hit on 0xC.
        for (int i = 0; i < LINE_W / 8; i++) pat[i*8 +: 8] = 8'h5A;
        access(5, 23'hC, 1, 1, pat, 1, 1);
        access(5, 23'hC, 1, 0, '0, 1, 0);

        // Set 15: ways 0..2 clean, way 3 dirty.
        access(15, 23'h100, 1, 0, rnd_line(), 1, 1);
        access(15, 23'h101, 1, 0, rnd_line(), 1, 1);
        access(15, 23'h102, 1, 0, rnd_line(), 1, 1);
        access(15, 23'h103, 1, 1, rnd_line(), 1, 1);

        // Flush with backpressure on the first line, then a clean flush.
        run_flush(3, 1'b0, -1);
        access(5, 23'hC, 1, 0, '0, 1, 0);
        access(15, 23'h103, 1, 0, '0, 1, 0);
        access(5, 23'h1ffff, 1, 0, '0, 1, 0);
        run_flush(0, 1'b0, SETS * WAYS);

        // Random accesses on a small tag/set space to force hits and evictions.
        for (int n = 0; n < 400; n++) begin
            access($urandom_range(0, 3), TAG_W'($urandom_range(0, 7)),
                   ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                   rnd_line(), ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)));
        end
        run_flush(0, 1'b1, -1);
        for (int n = 0; n < 60; n++)
            access($urandom_range(0, 3), TAG_W'($urandom_range(0, 7)), 1, 0, '0, 1, 0);

        // Reset while a dirty line is being presented.
        access(0, 23'h7, 1, 1, rnd_line(), 1, 1);
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1 bus.flush_i = 1'b0;
        k = 0; seen = 0;
        while (k < 200 && !seen) begin
            @(negedge clk);
            if (bus.flush_valid_o) seen = 1; else k++;
        end
        check("emit_before_reset", seen, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy",  bus.busy_o, 1'b0);
        check("abort_valid", bus.flush_valid_o, 1'b0);
        check("abort_done",  bus.flush_done_o, 1'b0);
        rst = 1'b1;
        m_reset();
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.flush_done_o) seen = 1;
        end
        check("no_done_after_abort", seen, 1'b0);
        for (int s = 0; s < SETS; s += 3)
            access(s, TAG_W'($urandom_range(0, 7)), 1, 0, '0, 1, 0);
        access(0, 23'h7, 1, 0, '0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
